// File: rtl/round_judge.sv
// Round judge and match scoreboard for the animal-duel game: validates one-hot choices,
// resolves by cyclic dominance, keeps saturating scores. Option: ROUND_JUDGE_INVALID_FORFEIT_EN.
module round_judge #(
   parameter int NUM_CHOICES = 3,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 9
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CHOICES-1:0]             p1_choice,
   input  logic [NUM_CHOICES-1:0]             p2_choice,
   input  logic                               round_go,
   input  logic                               clear_match,
   output logic                               busy,
   output logic                               result_valid,
   output logic [1:0]                         outcome,
   output logic [NUM_CHOICES*NUM_CHOICES-1:0] scenario,
   output logic [SCORE_W-1:0]                 score1,
   output logic [SCORE_W-1:0]                 score2,
   output logic                               match_over,
   output logic [1:0]                         match_winner,
   output logic [1:0]                         state_dbg
);

   localparam int IW     = $clog2(NUM_CHOICES);
   localparam int SCEN_W = NUM_CHOICES * NUM_CHOICES;
   localparam int HALF   = (NUM_CHOICES - 1) / 2;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [1:0] OUT_TIE = 2'b00;
   localparam logic [1:0] OUT_P1  = 2'b01;
   localparam logic [1:0] OUT_P2  = 2'b10;
   localparam logic [1:0] OUT_BAD = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REPORT, S_DONE} state_t;

   state_t state, state_next;

   logic [NUM_CHOICES-1:0] c1_q, c2_q;
   logic [1:0]             pend_outcome;
   logic [SCEN_W-1:0]      pend_scenario;

   logic              v1, v2;
   logic [IW-1:0]     i1, i2;
   logic [IW:0]       diff;
   logic [1:0]        eval_outcome;
   logic [SCEN_W-1:0] eval_scenario;
   logic              p1_inc, p2_inc, win_reached;
   logic [SCORE_W-1:0] new1, new2;

   function automatic logic [IW-1:0] to_index(input logic [NUM_CHOICES-1:0] v);
      to_index = '0;
      for (int i = 0; i < NUM_CHOICES; i++)
         if (v[i]) to_index = IW'(i);
   endfunction

   // Handshake: round_go is accepted only in IDLE (never queued); result_valid is a
   // one-cycle pulse with no backpressure. busy covers the whole round including the pulse.
   assign busy      = (state != S_IDLE) || result_valid;
   assign state_dbg = state;

   always_comb begin
      v1            = ($countones(c1_q) == 1);
      v2            = ($countones(c2_q) == 1);
      i1            = to_index(c1_q);
      i2            = to_index(c2_q);
      diff          = '0;
      eval_outcome  = OUT_BAD;
      eval_scenario = '0;
      // (i1 - i2) mod N without a divider: add N back when the difference would go negative
      if (i1 >= i2) diff = {1'b0, i1} - {1'b0, i2};
      else          diff = {1'b0, i1} + (IW+1)'(NUM_CHOICES) - {1'b0, i2};
      if (v1 && v2) begin
         eval_scenario = SCEN_W'(1) << (int'(i1) * NUM_CHOICES + int'(i2));
         if (diff == '0)                 eval_outcome = OUT_TIE;
         else if (int'(diff) <= HALF)    eval_outcome = OUT_P1;
         else                            eval_outcome = OUT_P2;
      end
`ifdef ROUND_JUDGE_INVALID_FORFEIT_EN
      else if (v1 && !v2) eval_outcome = OUT_P1;
      else if (!v1 && v2) eval_outcome = OUT_P2;
`endif
   end

   always_comb begin
      p1_inc      = (pend_outcome == OUT_P1);
      p2_inc      = (pend_outcome == OUT_P2);
      new1        = (score1 == SCORE_MAX) ? score1 : score1 + 1'b1;
      new2        = (score2 == SCORE_MAX) ? score2 : score2 + 1'b1;
      win_reached = (p1_inc && new1 == WIN_VAL) || (p2_inc && new2 == WIN_VAL);
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (round_go) state_next = S_EVAL;
         S_EVAL:   state_next = S_REPORT;
         S_REPORT: state_next = win_reached ? S_DONE : S_IDLE;
         S_DONE:   state_next = S_DONE;
         default:  state_next = S_IDLE;
      endcase
      if (clear_match) state_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c1_q          <= '0;
         c2_q          <= '0;
         pend_outcome  <= OUT_TIE;
         pend_scenario <= '0;
         result_valid  <= 1'b0;
         outcome       <= OUT_TIE;
         scenario      <= '0;
         score1        <= '0;
         score2        <= '0;
         match_over    <= 1'b0;
         match_winner  <= 2'b00;
      end else if (clear_match) begin
         pend_outcome  <= OUT_TIE;
         pend_scenario <= '0;
         result_valid  <= 1'b0;
         outcome       <= OUT_TIE;
         scenario      <= '0;
         score1        <= '0;
         score2        <= '0;
         match_over    <= 1'b0;
         match_winner  <= 2'b00;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_IDLE: if (round_go) begin
               c1_q <= p1_choice;
               c2_q <= p2_choice;
            end
            S_EVAL: begin
               pend_outcome  <= eval_outcome;
               pend_scenario <= eval_scenario;
            end
            S_REPORT: begin
               result_valid <= 1'b1;
               outcome      <= pend_outcome;
               scenario     <= pend_scenario;
               if (p1_inc) score1 <= new1;
               if (p2_inc) score2 <= new2;
               if (win_reached) begin
                  match_over   <= 1'b1;
                  match_winner <= p1_inc ? 2'b01 : 2'b10;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: a 3-animal instance (default parameters) and a
// 5-animal instance with SCORE_W=2, WIN_SCORE=3, both checked against hand-computed rounds.
module tb_round_judge;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // 3-animal instance
   logic [2:0] p1_a, p2_a;
   logic       go_a, clr_a;
   logic       busy_a, rv_a, mo_a;
   logic [1:0] out_a, mw_a, st_a;
   logic [8:0] scen_a;
   logic [3:0] s1_a, s2_a;
   logic [21:0] exp_a_q[$];

   // 5-animal instance
   logic [4:0]  p1_b, p2_b;
   logic        go_b, clr_b;
   logic        busy_b, rv_b, mo_b;
   logic [1:0]  out_b, mw_b, st_b, s1_b, s2_b;
   logic [24:0] scen_b;
   logic [33:0] exp_b_q[$];

   logic [3:0] s2_after;

   round_judge dut_a (
      .clk(clk), .reset(reset), .p1_choice(p1_a), .p2_choice(p2_a),
      .round_go(go_a), .clear_match(clr_a), .busy(busy_a), .result_valid(rv_a),
      .outcome(out_a), .scenario(scen_a), .score1(s1_a), .score2(s2_a),
      .match_over(mo_a), .match_winner(mw_a), .state_dbg(st_a)
   );

   round_judge #(.NUM_CHOICES(5), .SCORE_W(2), .WIN_SCORE(3)) dut_b (
      .clk(clk), .reset(reset), .p1_choice(p1_b), .p2_choice(p2_b),
      .round_go(go_b), .clear_match(clr_b), .busy(busy_b), .result_valid(rv_b),
      .outcome(out_b), .scenario(scen_b), .score1(s1_b), .score2(s2_b),
      .match_over(mo_b), .match_winner(mw_b), .state_dbg(st_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: pop one expected record per result_valid pulse
   always @(negedge clk) begin
      if (rv_a === 1'b1) begin
         logic [21:0] e, g;
         g = {out_a, scen_a, s1_a, s2_a, mo_a, mw_a};
         n_checks++;
         if (exp_a_q.size() == 0) begin
            n_errors++;
            $display("FAIL a_unexpected_result: got %0h expected no pulse", g);
         end else begin
            e = exp_a_q.pop_front();
            if (g !== e) begin
               n_errors++;
               $display("FAIL a_result: got out=%b scen=%b s1=%0d s2=%0d mo=%b mw=%b expected out=%b scen=%b s1=%0d s2=%0d mo=%b mw=%b",
                        g[21:20], g[19:11], g[10:7], g[6:3], g[2], g[1:0],
                        e[21:20], e[19:11], e[10:7], e[6:3], e[2], e[1:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rv_b === 1'b1) begin
         logic [33:0] e, g;
         g = {out_b, scen_b, s1_b, s2_b, mo_b, mw_b};
         n_checks++;
         if (exp_b_q.size() == 0) begin
            n_errors++;
            $display("FAIL b_unexpected_result: got %0h expected no pulse", g);
         end else begin
            e = exp_b_q.pop_front();
            if (g !== e) begin
               n_errors++;
               $display("FAIL b_result: got %0h expected %0h", g, e);
            end
         end
      end
   end

   // One round on instance a; inputs are scrambled after the accept edge on purpose
   task automatic round_a(input logic [2:0] p1, input logic [2:0] p2, input logic [1:0] eo,
                          input logic [8:0] esc, input logic [3:0] es1, input logic [3:0] es2,
                          input logic emo, input logic [1:0] emw);
      exp_a_q.push_back({eo, esc, es1, es2, emo, emw});
      @(negedge clk);
      p1_a = p1; p2_a = p2; go_a = 1'b1;
      @(negedge clk);
      go_a = 1'b0; p1_a = 3'b111; p2_a = 3'b000;
      repeat (2) @(negedge clk);
   endtask

   task automatic round_b(input logic [4:0] p1, input logic [4:0] p2, input logic [1:0] eo,
                          input logic [24:0] esc, input logic [1:0] es1, input logic [1:0] es2,
                          input logic emo, input logic [1:0] emw);
      exp_b_q.push_back({eo, esc, es1, es2, emo, emw});
      @(negedge clk);
      p1_b = p1; p2_b = p2; go_b = 1'b1;
      @(negedge clk);
      go_b = 1'b0; p1_b = 5'b0; p2_b = 5'b11111;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      p1_a = '0; p2_a = '0; go_a = 1'b0; clr_a = 1'b0;
      p1_b = '0; p2_b = '0; go_b = 1'b0; clr_b = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs_a", {busy_a, rv_a, out_a, scen_a, s1_a, s2_a, mo_a, mw_a}, 64'd0);
      check("reset_state_a", st_a, 64'd0);
      check("reset_outputs_b", {busy_b, rv_b, out_b, scen_b, s1_b, s2_b, mo_b, mw_b}, 64'd0);

      // cat vs dog, with latency and busy timing checked step by step
      exp_a_q.push_back({2'b10, 9'b000000010, 4'd0, 4'd1, 1'b0, 2'b00});
      p1_a = 3'b001; p2_a = 3'b010; go_a = 1'b1;
      @(negedge clk);
      go_a = 1'b0;
      check("busy_in_eval", busy_a, 64'd1);
      check("state_eval", st_a, 64'd1);
      @(negedge clk);
      check("no_early_valid", rv_a, 64'd0);
      @(negedge clk);
      check("valid_at_k2", rv_a, 64'd1);
      @(negedge clk);
      check("busy_falls_k3", busy_a, 64'd0);

      round_a(3'b100, 3'b001, 2'b10, 9'b001000000, 4'd0, 4'd2, 1'b0, 2'b00);
      round_a(3'b001, 3'b100, 2'b01, 9'b000000100, 4'd1, 4'd2, 1'b0, 2'b00);
      round_a(3'b010, 3'b010, 2'b00, 9'b000010000, 4'd1, 4'd2, 1'b0, 2'b00);
`ifdef ROUND_JUDGE_INVALID_FORFEIT_EN
      round_a(3'b011, 3'b001, 2'b10, 9'b000000000, 4'd1, 4'd3, 1'b0, 2'b00);
      s2_after = 4'd3;
`else
      round_a(3'b011, 3'b001, 2'b11, 9'b000000000, 4'd1, 4'd2, 1'b0, 2'b00);
      s2_after = 4'd2;
`endif
      round_a(3'b010, 3'b001, 2'b01, 9'b000001000, 4'd2, s2_after, 1'b0, 2'b00);
      round_a(3'b100, 3'b010, 2'b01, 9'b010000000, 4'd3, s2_after, 1'b0, 2'b00);
      round_a(3'b000, 3'b000, 2'b11, 9'b000000000, 4'd3, s2_after, 1'b0, 2'b00);

      // round_go held into EVAL must not start a second round
      exp_a_q.push_back({2'b01, 9'b000000100, 4'd4, s2_after, 1'b0, 2'b00});
      @(negedge clk);
      p1_a = 3'b001; p2_a = 3'b100; go_a = 1'b1;
      @(negedge clk);
      p1_a = 3'b010; p2_a = 3'b001;
      @(negedge clk);
      go_a = 1'b0;
      repeat (2) @(negedge clk);
      check("no_extra_result", rv_a, 64'd0);
      check("idle_after_held_go", st_a, 64'd0);

      // clear and round_go together: clear wins
      clr_a = 1'b1; go_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0; go_a = 1'b0;
      check("clear_outputs", {out_a, scen_a, s1_a, s2_a, mo_a, mw_a}, 64'd0);
      check("clear_drops_go", busy_a, 64'd0);
      repeat (3) @(negedge clk);

      // clear during EVAL abandons the round
      round_a(3'b001, 3'b100, 2'b01, 9'b000000100, 4'd1, 4'd0, 1'b0, 2'b00);
      p1_a = 3'b010; p2_a = 3'b001; go_a = 1'b1;
      @(negedge clk);
      go_a = 1'b0; clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clear_mid_round", s1_a, 64'd0);
      repeat (3) @(negedge clk);
      check("clear_mid_round_idle", {busy_a, s1_a}, 64'd0);

      // nine P1 wins end the match
      for (int i = 0; i < 9; i++)
         round_a(3'b010, 3'b001, 2'b01, 9'b000001000, 4'(i + 1), 4'd0, (i == 8), (i == 8) ? 2'b01 : 2'b00);
      check("match_over", {mo_a, mw_a}, 64'b101);
      check("done_state", {busy_a, st_a}, 64'b111);
      go_a = 1'b1;
      @(negedge clk);
      go_a = 1'b0;
      repeat (3) @(negedge clk);
      check("done_ignores_go", {s1_a, st_a}, {58'd0, 4'd9, 2'd3});
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clear_from_done", {busy_a, st_a, s1_a, s2_a, mo_a, mw_a}, 64'd0);

      // reset asserted in REPORT
      round_a(3'b001, 3'b100, 2'b01, 9'b000000100, 4'd1, 4'd0, 1'b0, 2'b00);
      p1_a = 3'b010; p2_a = 3'b001; go_a = 1'b1;
      @(negedge clk);
      go_a = 1'b0;
      @(negedge clk);
      check("state_report", st_a, 64'd2);
      reset = 1'b1;
      #1;
      check("reset_in_report", {busy_a, rv_a, out_a, scen_a, s1_a, s2_a, mo_a, mw_a, st_a}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("no_result_after_reset", s1_a, 64'd0);

      // five animals, two-bit scores, match at 3
      round_b(5'b01000, 5'b00010, 2'b01, 25'd1 << 16, 2'd1, 2'd0, 1'b0, 2'b00);
      round_b(5'b00010, 5'b10000, 2'b01, 25'd1 << 9,  2'd2, 2'd0, 1'b0, 2'b00);
      round_b(5'b00001, 5'b00100, 2'b10, 25'd1 << 2,  2'd2, 2'd1, 1'b0, 2'b00);
      round_b(5'b00100, 5'b00001, 2'b01, 25'd1 << 10, 2'd3, 2'd1, 1'b1, 2'b01);
      go_b = 1'b1; p1_b = 5'b01000; p2_b = 5'b00010;
      @(negedge clk);
      go_b = 1'b0;
      repeat (3) @(negedge clk);
      check("b_score_capped", {s1_b, st_b}, {60'd0, 2'd3, 2'd3});

      repeat (3) @(negedge clk);
      check("queue_a_drained", exp_a_q.size(), 64'd0);
      check("queue_b_drained", exp_b_q.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/round_judge.md
# round_judge

Parametrised round judge and match scoreboard for the animal-duel game. It validates two one-hot player choices, resolves the round by cyclic dominance over NUM_CHOICES animals, and emits a one-hot scenario vector for the sprite/controller path. It keeps saturating per-player scores for the HEX displays and flags the end of the match. It sits between the switch/key inputs and the game controller/datapath, and replaces the inline nine-way scenario decode.

## Interface
- NUM_CHOICES, 3, number of animals; odd, 3..7; index 0 = cat, 1 = dog, 2 = chicken, higher indices are new animals
- SCORE_W, 4, score register width
- WIN_SCORE, 9, score that ends the match; 1..2^SCORE_W-1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p1_choice  in  NUM_CHOICES  player 1 choice, one-hot
- p2_choice  in  NUM_CHOICES  player 2 choice, one-hot
- round_go  in  1  one-cycle request to judge the current choices
- clear_match  in  1  synchronous clear of scores and match state
- busy  out  1  high outside IDLE
- result_valid  out  1  one-cycle pulse; outcome, scenario and scores are valid
- outcome  out  2  00 tie, 01 P1 wins, 10 P2 wins, 11 invalid
- scenario  out  NUM_CHOICES*NUM_CHOICES  one-hot; bit p1_idx*NUM_CHOICES+p2_idx; held until the next round
- score1, score2  out  SCORE_W  player scores
- match_over  out  1  a score has reached WIN_SCORE
- match_winner  out  2  01 P1, 10 P2, 00 none

## Operation
- FSM states: IDLE, EVAL, REPORT, DONE.
- IDLE: on round_go, register p1_choice and p2_choice, then go to EVAL.
- EVAL:
  - Encode each registered choice to an index. A choice is valid only if it has exactly one bit set.
  - Dominance rule: d = (i1 - i2) mod NUM_CHOICES. d = 0 is a tie. d in 1..(NUM_CHOICES-1)/2 means P1 wins. Otherwise P2 wins.
  - For NUM_CHOICES = 3 this gives: dog beats cat, chicken beats dog, cat beats chicken.
  - Register outcome and scenario, then go to REPORT.
  - An invalid round gives outcome 11 and scenario all-zero.
- REPORT:
  - Pulse result_valid for one cycle.
  - The winner's score increments, saturating at 2^SCORE_W-1. Ties and invalid rounds change no score.
  - If the new score equals WIN_SCORE: set match_over, set match_winner, go to DONE. Otherwise go to IDLE.
- DONE: round_go is ignored; busy stays high. Only clear_match or reset leaves this state.
- clear_match, in any state:
  - Zero score1, score2, match_over, match_winner and scenario; set outcome to 00.
  - Next state is IDLE. Any in-flight round is abandoned and no result_valid is produced.
- clear_match and round_go in the same cycle: clear wins and round_go is dropped.
- round_go while busy (EVAL, REPORT, DONE): ignored, not queued.

## Timing
- Reset values: all outputs 0, state IDLE.
- round_go sampled at edge k:
  - EVAL during cycle k→k+1.
  - result_valid, outcome, scenario and the updated score are visible after edge k+2.
  - busy falls after edge k+3.
- Throughput: one round per 3 cycles.
- match_over and match_winner rise together with result_valid of the winning round.
- Inputs are sampled only at the round_go edge; later changes do not affect the round in flight.
- Reset asserted mid-round: immediate return to the reset values, and no result_valid pulse.

## Configuration
- ROUND_JUDGE_INVALID_FORFEIT_EN
  - Defined: if exactly one player's choice is invalid, the other player wins the round. The outcome is 01 or 10, their score increments, and scenario is all-zero. Both choices invalid still gives outcome 11 with no score.
  - Undefined: any invalid choice gives outcome 11 and no score change.

## Test plan
- Reset, then p1=001 (cat), p2=010 (dog), round_go → after 2 edges: result_valid=1, outcome=10, scenario bit 1 set, score2=1, score1=0.
- p1=100 (chicken), p2=001 (cat) → outcome 10; p1=001, p2=100 → outcome 01; p1=p2=010 → outcome 00, scenario bit 4, scores unchanged.
- p1=011, p2=001 → outcome 11, scenario 0, no score change. With the forfeit macro: outcome 10, score2 increments.
- Nine P1 wins with WIN_SCORE=9 → match_over=1 and match_winner=01 on the ninth result_valid; a further round_go gives no pulse; clear_match returns scores to 0 and the state to IDLE.
- round_go asserted again in EVAL, and round_go together with clear_match → no extra result, clear takes effect; reset asserted in REPORT → all outputs 0 immediately.
- NUM_CHOICES=5, SCORE_W=2, WIN_SCORE=3: index 3 vs 1 → P1 wins; index 1 vs 4 → P1 wins (d=2); index 0 vs 2 → P2 wins; scores never exceed 3.
